tile_order_reader: RTL and testbench
====================================

// Module: tile_order_reader
// PURPOSE
// Consumer side of the packed tile-order words produced by the random order generator.
// - Captures one 96-bit edge order (24 x 4-bit tile IDs) and one 48-bit centre order (12 x 4-bit IDs).
// - Validates both words, then serves tiles to game logic: current edge tile under a movable
//   pointer, the tile one step ahead, and registered centre-tile lookup by slot.
// PARAMETERS
// EDGE_SLOTS    24  number of edge slots; pointer range 0..EDGE_SLOTS-1
// CENTER_SLOTS  12  number of centre slots; centre IDs must be a permutation
// ID_W          4   bits per tile ID
// NUM_IDS       12  legal IDs are 0..NUM_IDS-1
// PORTS
// clk           in   1     system clock, all state on rising edge
// rst           in   1     asynchronous, active-high reset
// load          in   1     1-cycle pulse: capture order words, start validation
// edge_order    in   96    packed edge order; slot k = bits [95-4k -: 4] (slot 0 = MSBs)
// center_order  in   48    packed centre order; slot k = bits [47-4k -: 4]
// adv_valid     in   1     request to advance edge pointer
// adv_steps     in   3     advance amount 0..7
// adv_ready     out  1     high only in READY
// center_sel    in   4     centre slot to read (0..11)
// center_tile   out  4     registered centre ID for center_sel
// edge_pos      out  5     current edge pointer
// edge_tile     out  4     ID at edge_pos
// next_tile     out  4     ID at (edge_pos+1) mod 24
// wrap          out  1     1-cycle pulse: last advance crossed slot 23 -> 0
// order_err     out  1     captured order failed validation
// BEHAVIOUR
// - Reset: state=IDLE; stored words=0; edge_pos=0; edge_tile=next_tile=center_tile=0;
//   adv_ready=0; wrap=0; order_err=0; scan index=0; seen-bitmap=0.
// - FSM: IDLE -> CHECK on load; CHECK -> READY after last slot passes;
//   CHECK -> ERROR on first failing slot; READY/ERROR -> CHECK on load.
// - load is accepted in every state and has priority over a simultaneous advance.
//   Capture: store both words, edge_pos=0, seen-bitmap=0, index=0, order_err=0, wrap=0.
// - CHECK: one slot per cycle; index 0..23 = edge slots, 24..35 = centre slots.
//   - Edge slot fails if ID >= NUM_IDS.
//   - Centre slot fails if ID >= NUM_IDS or its seen-bitmap bit is already set; otherwise the bit is set.
//   - Error exits early: a bad slot at index s gives state=ERROR and order_err=1 at the (s+1)th edge after the load edge.
//   - No error: adv_ready=1 from the 36th edge after the load edge (load at E0, READY after E36).
// - ERROR: order_err held at 1; adv_ready=0; outputs frozen until the next load.
// - READY advance (handshake): occurs when adv_valid && adv_ready at a rising edge.
//   - sum = edge_pos + adv_steps (6-bit).
//   - If sum >= 24: edge_pos = sum - 24 and wrap=1 for exactly one cycle; else edge_pos = sum and wrap=0.
//   - adv_steps = 0 is accepted with no pointer change and no wrap.
//   - Back-to-back advances run every cycle. adv_valid outside READY is ignored, with no queuing.
// - edge_tile/next_tile are registered. They reflect the new pointer on the same edge that
//   updates edge_pos; latency is 1 cycle from the handshake. They are valid from READY entry.
// - center_tile = center slot center_sel, 1-cycle latency, in READY only; otherwise it holds.
//   center_sel > 11 returns 0.
// - Async rst mid-CHECK or mid-READY returns to IDLE immediately; a new load is then required.
// TESTING
// 1. Edge 0..11,0..11 and centre 0..11, load at E0 -> adv_ready=1 after E36; edge_tile=0, next_tile=1, order_err=0.
// 2. From case 1: advance by 5, then by 7 -> edge_pos=5 (tile 5, next 6), then 12 (tile 0); no wrap.
// 3. With edge_pos=22, advance by 3 -> edge_pos=1, edge_tile=1, wrap pulsed exactly one cycle; steps=0 -> no change.
// 4. Centre order all zeros -> centre slot 1 (index 25) duplicates; order_err=1 after E26; adv_ready stays 0.
// 5. Edge slot 3 = 4'hF -> order_err=1 after E4; a later valid load clears order_err and reaches READY 36 cycles later.
// 6. rst asserted mid-CHECK -> IDLE and all outputs 0 at once. load with adv_valid in READY -> load wins, edge_pos=0.

Source files
------------

// File: rtl/tile_order_reader.sv
// tile_order_reader: validates captured edge/centre tile orders, then serves edge tiles under an
// advancing pointer and registered centre-tile lookups.
module tile_order_reader #(
   parameter int EDGE_SLOTS   = 24,
   parameter int CENTER_SLOTS = 12,
   parameter int ID_W         = 4,
   parameter int NUM_IDS      = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [EDGE_SLOTS*ID_W-1:0]     edge_order,
   input  logic [CENTER_SLOTS*ID_W-1:0]   center_order,
   input  logic                           adv_valid,
   input  logic [2:0]                     adv_steps,
   output logic                           adv_ready,
   input  logic [$clog2(CENTER_SLOTS)-1:0] center_sel,
   output logic [ID_W-1:0]                center_tile,
   output logic [$clog2(EDGE_SLOTS)-1:0]  edge_pos,
   output logic [ID_W-1:0]                edge_tile,
   output logic [ID_W-1:0]                next_tile,
   output logic                           wrap,
   output logic                           order_err
);
   localparam int TOT = EDGE_SLOTS + CENTER_SLOTS;
   localparam int IW  = $clog2(TOT);
   localparam int PW  = $clog2(EDGE_SLOTS);
   localparam int CW  = $clog2(CENTER_SLOTS);
   typedef enum logic [1:0] {IDLE, CHECK, READY, ERROR} state_t;
   state_t state, state_n;
   logic [ID_W-1:0] edge_a [EDGE_SLOTS];
   logic [ID_W-1:0] center_a [CENTER_SLOTS];
   logic [IW-1:0] idx;
   logic [CW-1:0] cidx;
   logic [2**ID_W-1:0] seen;
   logic [ID_W-1:0] cur_id;
   logic cur_edge, bad, last, adv, crossed;
   logic [PW:0] sum;
   logic [PW-1:0] pos_n, pos_p1;

   // index 0..EDGE_SLOTS-1 walks edge slots, the rest walks centre slots
   assign cur_edge  = idx < IW'(EDGE_SLOTS);
   assign cidx      = CW'(idx - IW'(EDGE_SLOTS));
   assign cur_id    = cur_edge ? edge_a[idx[PW-1:0]] : center_a[cidx];
   assign bad       = cur_id >= ID_W'(NUM_IDS) || (!cur_edge && seen[cur_id]);
   assign last      = idx == IW'(TOT - 1);
   assign adv       = state == READY && adv_valid && !load;
   assign sum       = {1'b0, edge_pos} + (PW+1)'(adv_steps);
   assign crossed   = sum >= (PW+1)'(EDGE_SLOTS);
   assign pos_n     = adv ? (crossed ? PW'(sum - (PW+1)'(EDGE_SLOTS)) : sum[PW-1:0]) : load ? '0 : edge_pos;
   assign pos_p1    = pos_n == PW'(EDGE_SLOTS - 1) ? '0 : pos_n + 1'b1;
   assign adv_ready = state == READY;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_comb begin
      state_n = state;
      if (load) state_n = CHECK;
      else if (state == CHECK) state_n = bad ? ERROR : last ? READY : CHECK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < EDGE_SLOTS; k++) edge_a[k] <= '0;
         for (int k = 0; k < CENTER_SLOTS; k++) center_a[k] <= '0;
         idx         <= '0;
         seen        <= '0;
         edge_pos    <= '0;
         edge_tile   <= '0;
         next_tile   <= '0;
         center_tile <= '0;
         wrap        <= 1'b0;
         order_err   <= 1'b0;
      end else if (load) begin
         for (int k = 0; k < EDGE_SLOTS; k++) edge_a[k] <= edge_order[(EDGE_SLOTS-1-k)*ID_W +: ID_W];
         for (int k = 0; k < CENTER_SLOTS; k++) center_a[k] <= center_order[(CENTER_SLOTS-1-k)*ID_W +: ID_W];
         idx       <= '0;
         seen      <= '0;
         edge_pos  <= '0;
         wrap      <= 1'b0;
         order_err <= 1'b0;
      end else begin
         wrap <= adv && crossed;
         if (state == CHECK) begin
            idx <= idx + 1'b1;
            if (!cur_edge) seen[cur_id] <= 1'b1;
            if (bad) order_err <= 1'b1;
         end
         if (adv) edge_pos <= pos_n;
         // tiles load on READY entry (pointer 0) and follow every accepted advance
         if (state_n == READY) begin
            edge_tile <= edge_a[pos_n];
            next_tile <= edge_a[pos_p1];
         end
         if (state == READY)
            center_tile <= center_sel < CW'(CENTER_SLOTS) ? center_a[center_sel] : '0;
      end
   end
endmodule

// File: tb/tb_tile_order_reader.sv
// tb_tile_order_reader: randomized and directed checks of tile_order_reader against an
// array-based reference of the validation and pointer rules.
module tb_tile_order_reader;
   logic clk = 0, rst = 1, load = 0, adv_valid = 0;
   logic [2:0] adv_steps = 0;
   logic [3:0] center_sel = 0;
   logic [95:0] edge_order = 0;
   logic [47:0] center_order = 0;
   logic adv_ready, wrap, order_err;
   logic [3:0] center_tile, edge_tile, next_tile;
   logic [4:0] edge_pos;

   tile_order_reader dut (
      .clk(clk), .rst(rst), .load(load), .edge_order(edge_order), .center_order(center_order),
      .adv_valid(adv_valid), .adv_steps(adv_steps), .adv_ready(adv_ready), .center_sel(center_sel),
      .center_tile(center_tile), .edge_pos(edge_pos), .edge_tile(edge_tile), .next_tile(next_tile),
      .wrap(wrap), .order_err(order_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int e[24], c[12];
   int pos = 0, etile_m = 0, ntile_m = 0, ctile_m = 0;
   bit ready_m = 0, err_m = 0;

   task automatic check(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int first_bad();
      bit seen[12];
      for (int s = 0; s < 24; s++) if (e[s] >= 12) return s;
      for (int j = 0; j < 12; j++) begin
         if (c[j] >= 12 || seen[c[j]]) return 24 + j;
         seen[c[j]] = 1;
      end
      return -1;
   endfunction

   task automatic check_all(string tag);
      check({tag, "_pos"}, int'(edge_pos), pos);
      check({tag, "_etile"}, int'(edge_tile), etile_m);
      check({tag, "_ntile"}, int'(next_tile), ntile_m);
      check({tag, "_ctile"}, int'(center_tile), ctile_m);
      check({tag, "_ready"}, int'(adv_ready), int'(ready_m));
      check({tag, "_err"}, int'(order_err), int'(err_m));
   endtask

   task automatic run_order(bit with_adv);
      int s;
      s = first_bad();
      for (int k = 0; k < 24; k++) edge_order[95-4*k -: 4] = 4'(e[k]);
      for (int k = 0; k < 12; k++) center_order[47-4*k -: 4] = 4'(c[k]);
      load = 1; adv_valid = with_adv; adv_steps = 3;
      @(negedge clk);
      load = 0;
      pos = 0; ready_m = 0; err_m = 0;
      check("load_wrap", int'(wrap), 0);
      check_all("load");
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (s > 0 && k == s) check("pre_err", int'(order_err), 0);
         if (s >= 0 && k == s + 1) begin
            err_m = 1;
            check_all("err_entry");
            break;
         end
         if (s < 0 && k == 35) check("pre_ready", int'(adv_ready), 0);
         if (s < 0 && k == 36) begin
            ready_m = 1; etile_m = e[0]; ntile_m = e[1];
            check_all("ready_entry");
         end
      end
      adv_valid = 0;
   endtask

   task automatic step(bit v, int st, int sel);
      bit wrap_m;
      adv_valid = v; adv_steps = 3'(st); center_sel = 4'(sel);
      @(negedge clk);
      wrap_m = 0;
      if (ready_m) begin
         if (v) begin
            wrap_m = pos + st >= 24;
            pos = (pos + st) % 24;
         end
         etile_m = e[pos]; ntile_m = e[(pos + 1) % 24];
         ctile_m = sel < 12 ? c[sel] : 0;
      end
      check("step_wrap", int'(wrap), int'(wrap_m));
      check_all("step");
      adv_valid = 0;
   endtask

   task automatic base_order();
      for (int k = 0; k < 24; k++) e[k] = k % 12;
      for (int k = 0; k < 12; k++) c[k] = k;
   endtask

   initial begin
      #1;
      check("rst_wrap", int'(wrap), 0);
      check_all("rst");
      @(negedge clk);
      rst = 0;
      step(1, 5, 0);
      base_order();
      run_order(0);
      step(1, 5, 3);
      step(1, 7, 11);
      step(1, 7, 12);
      step(1, 3, 15);
      step(1, 3, 0);
      check("wrap_pos", int'(edge_pos), 1);
      step(1, 0, 5);
      step(0, 4, 2);
      run_order(1);
      step(1, 6, 4);
      for (int k = 0; k < 12; k++) c[k] = 0;
      run_order(0);
      repeat (3) step(1, 2, 1);
      base_order();
      e[3] = 15;
      run_order(0);
      step(1, 1, 0);
      e[3] = 3;
      run_order(0);
      step(1, 4, 7);
      load = 1;
      @(negedge clk);
      load = 0;
      repeat (10) @(negedge clk);
      #2 rst = 1;
      #1;
      pos = 0; etile_m = 0; ntile_m = 0; ctile_m = 0; ready_m = 0; err_m = 0;
      check("arst_wrap", int'(wrap), 0);
      check_all("arst");
      @(negedge clk);
      rst = 0;
      step(1, 3, 0);
      repeat (25) begin
         int r, i, j, t;
         for (int k = 0; k < 24; k++) e[k] = $urandom_range(0, 11);
         for (int k = 0; k < 12; k++) c[k] = k;
         for (int k = 11; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = c[k]; c[k] = c[j]; c[j] = t;
         end
         r = $urandom_range(0, 7);
         i = $urandom_range(0, 11);
         if (r == 0) e[$urandom_range(0, 23)] = $urandom_range(12, 15);
         if (r == 1) c[i] = c[$urandom_range(0, 11)];
         if (r == 2) c[i] = $urandom_range(12, 15);
         run_order(1'($urandom_range(0, 1)));
         repeat (20) step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
